// File: rtl/tt_sel_pkg.sv
// Shared definitions for the mux select-bus decoder.
//   sel_state_e   : decoder FSM states
//   AddrWDefault  : default address counter width
//   GuardW        : width of the post-match quiet-interval counter
package tt_sel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StSettle,
    StActive
  } sel_state_e;

  localparam int unsigned AddrWDefault = 10;
  localparam int unsigned GuardW       = 4;

endpackage

// File: rtl/tt_sel_sync.sv
// Two-flop synchronizer for asynchronous control levels, reset to 0.
// Ports:
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d_i    : asynchronous input bits
//   q_o    : synchronized bits, two clk edges behind d_i
module tt_sel_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tt_sel_decoder.sv
// Receive-side decoder for the mux select bus. Counts increment pulses after a
// clear, compares the count with this unit's address, and after the bus has been
// quiet for GUARD_CYCLES cycles raises a registered enable to the user design.
//
// Build option: define TT_SEL_DECODER_SYNC_EN to pass sel_clr, sel_inc and
// ctrl_ena through 2-flop synchronizers (adds 2 cycles to every input-to-output
// latency). Without it the inputs must be synchronous to clk.
//
// Ports:
//   clk          : block clock
//   rst_n        : asynchronous active-low reset
//   sel_clr      : level, synchronous clear of the address counter
//   sel_inc      : increment strobe, each rising edge counts once
//   ctrl_ena     : global enable from the controller
//   ena_o        : registered enable to the selected design
//   sel_match_o  : registered (count == ADDR)
//   cnt_o        : current counter value
//   ovf_o        : sticky, increment seen while the counter was saturated
module tt_sel_decoder
  import tt_sel_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDefault,
  parameter int unsigned ADDR         = 0,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_clr,
  input  logic              sel_inc,
  input  logic              ctrl_ena,
  output logic              ena_o,
  output logic              sel_match_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] CntMax    = '1;
  localparam logic [ADDR_W-1:0] AddrVal   = ADDR_W'(ADDR);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  logic sel_clr_s;
  logic sel_inc_s;
  logic ctrl_ena_s;

`ifdef TT_SEL_DECODER_SYNC_EN
  logic [2:0] sync_out;

  tt_sel_sync #(
    .Width(3)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({sel_clr, sel_inc, ctrl_ena}),
    .q_o  (sync_out)
  );

  assign {sel_clr_s, sel_inc_s, ctrl_ena_s} = sync_out;
`else
  assign sel_clr_s  = sel_clr;
  assign sel_inc_s  = sel_inc;
  assign ctrl_ena_s = ctrl_ena;
`endif

  sel_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              inc_q;
  logic              ovf_q, ovf_d;
  logic              ena_q;
  logic              match_q;
  logic              inc_edge;
  logic              bus_busy;

  always_comb begin
    inc_edge = sel_inc_s & ~inc_q;
    // Any bus activity or loss of the global enable aborts the guard interval.
    bus_busy = inc_edge | sel_clr_s | ~ctrl_ena_s;
    state_d  = state_q;
    cnt_d    = cnt_q;
    guard_d  = guard_q;
    ovf_d    = ovf_q;

    // Clear beats a coincident increment; increments are ignored until the
    // first clear has taken the FSM out of idle.
    if (sel_clr_s) begin
      cnt_d   = '0;
      ovf_d   = 1'b0;
      guard_d = '0;
    end else if (inc_edge && (state_q != StIdle)) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sel_clr_s) state_d = StCount;
      end
      StCount: begin
        if (!bus_busy && (cnt_q == AddrVal)) begin
          state_d = StSettle;
          guard_d = '0;
        end
      end
      StSettle: begin
        if (bus_busy) begin
          state_d = StCount;
        end else begin
          guard_d = guard_q + 1'b1;
          if (guard_q == GuardLast) state_d = StActive;
        end
      end
      StActive: begin
        if (bus_busy) state_d = StCount;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      guard_q <= '0;
      inc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ena_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      inc_q   <= sel_inc_s;
      ovf_q   <= ovf_d;
      ena_q   <= (state_d == StActive);
      match_q <= (cnt_d == AddrVal);
    end
  end

  assign ena_o       = ena_q;
  assign sel_match_o = match_q;
  assign cnt_o       = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_tt_sel_decoder.sv
// Directed bench for tt_sel_decoder: instance a (ADDR_W=10, ADDR=3, GUARD=4)
// and instance b (ADDR_W=3, ADDR=6, GUARD=4) for the saturation cases.
module tb_tt_sel_decoder;

`ifdef TT_SEL_DECODER_SYNC_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_clr, a_inc, a_ena;
  logic       a_ena_o, a_match, a_ovf;
  logic [9:0] a_cnt;
  logic       b_clr, b_inc, b_ena;
  logic       b_ena_o, b_match, b_ovf;
  logic [2:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  tt_sel_decoder #(
    .ADDR_W      (10),
    .ADDR        (3),
    .GUARD_CYCLES(4)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_clr    (a_clr),
    .sel_inc    (a_inc),
    .ctrl_ena   (a_ena),
    .ena_o      (a_ena_o),
    .sel_match_o(a_match),
    .cnt_o      (a_cnt),
    .ovf_o      (a_ovf)
  );

  tt_sel_decoder #(
    .ADDR_W      (3),
    .ADDR        (6),
    .GUARD_CYCLES(4)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_clr    (b_clr),
    .sel_inc    (b_inc),
    .ctrl_ena   (b_ena),
    .ena_o      (b_ena_o),
    .sel_match_o(b_match),
    .cnt_o      (b_cnt),
    .ovf_o      (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int i = 0; i < int'(n); i++) tick();
  endtask

  // One-cycle increment pulse followed by one quiet cycle.
  task automatic pulse_inc_a();
    a_inc = 1'b1;
    tick();
    a_inc = 1'b0;
    tick();
  endtask

  task automatic pulse_inc_b();
    b_inc = 1'b1;
    tick();
    b_inc = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_clr = 1'b0; a_inc = 1'b0; a_ena = 1'b0;
    b_clr = 1'b0; b_inc = 1'b0; b_ena = 1'b0;
    #1;
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL reset_ena: got %b want 0", a_ena_o); n_fail++; end
    n_checks++;
    if (a_cnt !== 10'd0) begin $display("FAIL reset_cnt: got %0d want 0", a_cnt); n_fail++; end
    n_checks++;
    if (a_match !== 1'b0) begin $display("FAIL reset_match: got %b want 0", a_match); n_fail++; end
    n_checks++;
    if (a_ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b want 0", a_ovf); n_fail++; end
    ticks(2);
    rst_n = 1'b1;
    tick();
    // Increments before the first clear must be ignored.
    pulse_inc_a();
    ticks(Lat + 1);
    n_checks++;
    if (a_cnt !== 10'd0) begin $display("FAIL idle_inc_ignored: got %0d want 0", a_cnt); n_fail++; end
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL idle_ena: got %b want 0", a_ena_o); n_fail++; end
  endtask

  task automatic test_select();
    a_ena = 1'b1;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    pulse_inc_a();
    pulse_inc_a();
    pulse_inc_a();
    ticks(Lat);
    // Now at the edge that entered SETTLE.
    n_checks++;
    if (a_cnt !== 10'd3) begin $display("FAIL sel_cnt: got %0d want 3", a_cnt); n_fail++; end
    n_checks++;
    if (a_match !== 1'b1) begin $display("FAIL sel_match: got %b want 1", a_match); n_fail++; end
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL sel_guard0: got %b want 0", a_ena_o); n_fail++; end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++;
      if (a_ena_o !== 1'b0) begin
        $display("FAIL sel_guard%0d: got %b want 0", i, a_ena_o); n_fail++;
      end
    end
    tick();
    n_checks++;
    if (a_ena_o !== 1'b1) begin $display("FAIL sel_ena_rise: got %b want 1", a_ena_o); n_fail++; end
    ticks(3);
    n_checks++;
    if (a_ena_o !== 1'b1) begin $display("FAIL sel_ena_hold: got %b want 1", a_ena_o); n_fail++; end
  endtask

  task automatic test_active_inc();
    a_inc = 1'b1;
    tick();
    a_inc = 1'b0;
    ticks(Lat);
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL act_inc_ena: got %b want 0", a_ena_o); n_fail++; end
    n_checks++;
    if (a_cnt !== 10'd4) begin $display("FAIL act_inc_cnt: got %0d want 4", a_cnt); n_fail++; end
    n_checks++;
    if (a_match !== 1'b0) begin $display("FAIL act_inc_match: got %b want 0", a_match); n_fail++; end
  endtask

  task automatic test_hold_inc();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_inc = 1'b1;
    ticks(10);
    a_inc = 1'b0;
    ticks(Lat + 1);
    n_checks++;
    if (a_cnt !== 10'd1) begin $display("FAIL hold_inc_cnt: got %0d want 1", a_cnt); n_fail++; end
    a_clr = 1'b1;
    a_inc = 1'b1;
    tick();
    a_clr = 1'b0;
    a_inc = 1'b0;
    ticks(Lat);
    n_checks++;
    if (a_cnt !== 10'd0) begin $display("FAIL clr_wins_cnt: got %0d want 0", a_cnt); n_fail++; end
    ticks(2);
    n_checks++;
    if (a_cnt !== 10'd0) begin $display("FAIL clr_wins_later: got %0d want 0", a_cnt); n_fail++; end
  endtask

  task automatic test_guard_abort();
    pulse_inc_a();
    pulse_inc_a();
    pulse_inc_a();
    // Drop ctrl_ena so it takes effect while guard == 2.
    ticks(2);
    a_ena = 1'b0;
    ticks(Lat + 1);
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL abort_ena: got %b want 0", a_ena_o); n_fail++; end
    ticks(4);
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL abort_ena_stays: got %b want 0", a_ena_o); n_fail++; end
    n_checks++;
    if (a_cnt !== 10'd3) begin $display("FAIL abort_cnt: got %0d want 3", a_cnt); n_fail++; end
    a_ena = 1'b1;
    ticks(Lat + 1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_ena_o !== 1'b0) begin
        $display("FAIL restart_guard%0d: got %b want 0", i, a_ena_o); n_fail++;
      end
      if (i < 3) tick();
    end
    tick();
    n_checks++;
    if (a_ena_o !== 1'b1) begin $display("FAIL restart_ena_rise: got %b want 1", a_ena_o); n_fail++; end
  endtask

  task automatic test_saturate();
    b_ena = 1'b1;
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    for (int i = 0; i < 7; i++) pulse_inc_b();
    ticks(Lat);
    n_checks++;
    if (b_cnt !== 3'd7) begin $display("FAIL sat7_cnt: got %0d want 7", b_cnt); n_fail++; end
    n_checks++;
    if (b_ovf !== 1'b0) begin $display("FAIL sat7_ovf: got %b want 0", b_ovf); n_fail++; end
    pulse_inc_b();
    ticks(Lat);
    n_checks++;
    if (b_cnt !== 3'd7) begin $display("FAIL sat8_cnt: got %0d want 7", b_cnt); n_fail++; end
    n_checks++;
    if (b_ovf !== 1'b1) begin $display("FAIL sat8_ovf: got %b want 1", b_ovf); n_fail++; end
    n_checks++;
    if (b_ena_o !== 1'b0) begin $display("FAIL sat8_ena: got %b want 0", b_ena_o); n_fail++; end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    ticks(Lat);
    n_checks++;
    if (b_ovf !== 1'b0) begin $display("FAIL sat_clr_ovf: got %b want 0", b_ovf); n_fail++; end
    n_checks++;
    if (b_cnt !== 3'd0) begin $display("FAIL sat_clr_cnt: got %0d want 0", b_cnt); n_fail++; end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (a_ena_o !== 1'b1) begin $display("FAIL arst_pre_ena: got %b want 1", a_ena_o); n_fail++; end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL arst_ena: got %b want 0", a_ena_o); n_fail++; end
    n_checks++;
    if (a_cnt !== 10'd0) begin $display("FAIL arst_cnt: got %0d want 0", a_cnt); n_fail++; end
    n_checks++;
    if (a_match !== 1'b0) begin $display("FAIL arst_match: got %b want 0", a_match); n_fail++; end
    tick();
    rst_n = 1'b1;
    ticks(Lat + 2);
    n_checks++;
    if (a_ena_o !== 1'b0) begin $display("FAIL arst_post_ena: got %b want 0", a_ena_o); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_select();
    test_active_inc();
    test_hold_inc();
    test_guard_abort();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sel_decoder.md
Name: tt_sel_decoder

Overview:
- Receive-side decoder for the mux select bus.
- The controller drives a clear pulse plus a train of increment pulses through tt_prim_buf buffer chains. Each tile/mux unit counts the increments and compares the count against its hardwired address.
- Once the count matches and the bus has been quiet for a guard interval, the block asserts a registered enable toward the user design.
- One instance per mux unit, placed at the far end of the buffered select spine.

Parameters:
- ADDR_W, 10, width of the address counter.
- ADDR, 0, local address this instance answers to (0 .. 2^ADDR_W-2).
- GUARD_CYCLES, 4, quiet cycles required after match before enable (1..15).

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset.
- sel_clr  input  1  level, synchronous clear of the address counter.
- sel_inc  input  1  increment strobe; each rising edge counts once.
- ctrl_ena  input  1  global enable from the controller.
- ena_o  output  1  registered enable to the selected design.
- sel_match_o  output  1  registered (cnt == ADDR).
- cnt_o  output  ADDR_W  current counter value.
- ovf_o  output  1  sticky: increment seen while counter saturated.

Behaviour:
- Clock and reset
  - Single clock clk; reset is asynchronous and active-low on rst_n.
  - Reset: state=IDLE, cnt=0, guard=0, inc_q=0, ena_o=0, sel_match_o=0, ovf_o=0.
- Edge detect
  - inc_q <= sel_inc.
  - inc_edge = sel_inc & ~inc_q (one-cycle strobe).
  - Holding sel_inc high counts once.
- Counter
  - On inc_edge: cnt <= cnt+1, saturating at 2^ADDR_W-1.
  - inc_edge while saturated: cnt held, ovf_o <= 1.
  - sel_clr high at an edge: cnt <= 0, ovf_o <= 0, guard <= 0.
  - sel_clr and inc_edge in the same cycle: clear wins, the increment is dropped.
- sel_match_o <= (next cnt == ADDR), one cycle after the counter updates.
- FSM states: IDLE, COUNT, SETTLE, ACTIVE.
  - IDLE: ena_o=0. sel_clr -> COUNT. inc_edge is ignored; cnt stays 0 until the first clear.
  - COUNT: counts. If no inc_edge, no sel_clr, ctrl_ena=1 and cnt==ADDR -> SETTLE with guard <= 0.
  - SETTLE: guard <= guard+1 each cycle. inc_edge, sel_clr or ctrl_ena=0 -> COUNT (counter updated as above). guard==GUARD_CYCLES-1 -> ACTIVE.
  - ACTIVE: ena_o=1. inc_edge, sel_clr or ctrl_ena=0 -> COUNT.
- ena_o timing
  - ena_o is registered: ena_o <= (next_state==ACTIVE).
  - It rises exactly GUARD_CYCLES edges after the edge that entered SETTLE.
  - It falls on the same edge that leaves ACTIVE.
- Reset asserted mid-operation: all state clears immediately; ena_o drops asynchronously.

Optional Feature:
- Macro TT_SEL_DECODER_SYNC_EN.
- Defined: sel_clr, sel_inc and ctrl_ena each pass through a 2-flop synchronizer, reset to 0, before use. All input-to-output latencies grow by 2 cycles. Edge detection operates on the synchronized sel_inc.
- Undefined: inputs are used directly and must be synchronous to clk.

Decomposition:
- Shared package tt_sel_pkg:
  - state enum (IDLE, COUNT, SETTLE, ACTIVE).
  - default ADDR_W.
  - guard counter width constant (4 bits).
- One natural sub-module: tt_sel_sync, the 2-flop synchronizer, instantiated only under TT_SEL_DECODER_SYNC_EN.
- Counter and FSM stay in the top module.

Test Plan (ADDR=3, GUARD_CYCLES=4 unless noted):
- Release reset, pulse sel_clr, three 1-cycle sel_inc pulses spaced 2 cycles, ctrl_ena=1 -> cnt_o=3, sel_match_o=1; ena_o rises exactly 4 cycles after SETTLE entry and stays 1.
- While ACTIVE, a fourth sel_inc pulse -> ena_o falls on that edge, cnt_o=4, sel_match_o=0.
- sel_inc held high 10 cycles after clr -> cnt_o=1; sel_clr and sel_inc rising together -> cnt_o=0.
- In SETTLE at guard=2, drop ctrl_ena -> back to COUNT, ena_o stays 0. Re-raise ctrl_ena -> full 4-cycle guard restarts.
- ADDR_W=3, ADDR=6: 8 increments -> cnt_o=7, ovf_o=1, ena_o=0; sel_clr -> ovf_o=0.
- Assert rst_n low while ACTIVE, between clock edges -> ena_o=0 immediately, cnt_o=0. With TT_SEL_DECODER_SYNC_EN, scenario 1 shows ena_o 2 cycles later.
